i2c_reg_sequencer: RTL
======================

# i2c_reg_sequencer

Register-access controller that sits in front of the single-master `i2c` block and sequences its byte-level commands into complete 8-bit-register write and read transactions. It accepts one request at a time (device address, register address, write data) over a valid/ready handshake. It issues the start, address, data, restart and stop commands with the correct ordering and spacing, detects slave NACKs, and returns a one-cycle response carrying read data and error status.

## Interface
- `RETRIES`, 3: extra attempts after a NACK (used only with `I2C_SEQ_RETRY_EN`), 0..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle, accepts request.
- `req_rw`  in  1  0 = register write, 1 = register read.
- `req_dev_addr`  in  7  7-bit slave address.
- `req_reg_addr`  in  8  register index.
- `req_wdata`  in  8  write data (ignored for reads).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; 0 for writes and errors.
- `rsp_err`  out  1  transaction ended on a NACK.
- `rsp_err_stage`  out  2  NACK point: 0 dev-write addr, 1 reg addr, 2 wdata, 3 dev-read addr.
- `i2c_cmd`  out  3  to master `cmd`: 000 start, 001 restart, 010 stop, 011 read, 100 write.
- `i2c_data`  out  8  to master `data_in`.
- `i2c_write`  out  1  to master `write`; single-cycle command strobe.
- `i2c_ready`  in  1  from master `ready`.
- `i2c_done_tick`  in  1  from master `done_tick`.
- `i2c_ack`  in  1  from master `ack`; 0 = slave ACK, 1 = NACK.
- `i2c_rdata`  in  8  from master `data_out`.

## Operation
- States: IDLE, START, DEVW, REG, WDATA, RESTART, DEVR, READ, STOP, RESP.
- Write sequence: START → DEVW (`{addr,1'b0}`) → REG → WDATA → STOP → RESP.
- Read sequence: START → DEVW → REG → RESTART → DEVR (`{addr,1'b1}`) → READ (`i2c_data`=8'h01, master NACKs the final byte) → STOP → RESP.
- Each command state has two phases:
  - Issue: wait for `i2c_ready`=1, then assert `i2c_write` for exactly one cycle with `i2c_cmd`/`i2c_data` stable.
  - Wait: the cycle after issue is a mandatory gap in which `i2c_ready` is ignored. After the gap, start/restart/stop states wait for `i2c_ready`=1; write/read states wait for `i2c_done_tick`.
- On `i2c_done_tick` in DEVW/REG/WDATA/DEVR, sample `i2c_ack`. If it is 1, record the stage, set the error flag and go to STOP.
- On `i2c_done_tick` in READ, capture `i2c_rdata`.
- Request fields are latched on acceptance. Later changes to the request inputs have no effect.
- `i2c_write` is never asserted in IDLE or RESP.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_err_stage`=0, `i2c_write`=0, `i2c_cmd`=000, `i2c_data`=0.
- `req_ready` is registered. It rises the first cycle after reset deasserts and stays high only in IDLE.
- Acceptance happens when `req_valid && req_ready`. `req_ready` drops the next cycle.
- First `i2c_write` occurs no earlier than 1 cycle after acceptance.
- `rsp_valid` pulses 1 cycle after STOP completes (`i2c_ready` high again).
- `rsp_*` fields are valid only during the `rsp_valid` cycle and hold their value until the next response.
- `req_ready` is high the cycle after `rsp_valid`.
- Back-to-back requests: a request held valid during the `req_ready` cycle is accepted with zero idle gap.
- `i2c_done_tick` or `i2c_ready` arriving in the gap cycle is ignored. The master never produces that case.
- Reset mid-transaction: all outputs return to reset values immediately. No stop is issued; the master shares `reset_n`.

## Configuration
- `I2C_SEQ_RETRY_EN` defined: after a NACK-terminated STOP, if attempts so far ≤ `RETRIES`, return to START with the latched request and no `rsp_valid`. The counter clears on acceptance. `rsp_err` is reported only after the final failed attempt. A success on any attempt gives `rsp_err`=0.
- Undefined: the first NACK goes directly to STOP → RESP with `rsp_err`=1. `RETRIES` is unused and there is no retry counter.

## Test plan
- Write dev 7'h50, reg 8'h10, data 8'hA5, all ACK → master sees start, write 8'hA0, write 8'h10, write 8'hA5, stop; `rsp_valid` once, `rsp_err`=0, `rsp_rdata`=0.
- Read dev 7'h50, reg 8'h22, slave returns 8'h3C → start, write 8'hA0, write 8'h22, restart, write 8'hA1, read with data 8'h01, stop; `rsp_rdata`=8'h3C.
- Write with NACK on reg byte, retry off → stop issued right after reg byte, no WDATA; `rsp_err`=1, `rsp_err_stage`=1.
- Retry on, `RETRIES`=2, device NACKs 8'hA0 always → exactly 3 start/stop attempts, one `rsp_valid` with `rsp_err`=1, stage 0. A second run that ACKs on the 2nd attempt → `rsp_err`=0.
- `i2c_ready` held low 20 cycles before each command → `i2c_write` never asserted while ready=0, always a 1-cycle pulse.
- `reset_n` low during DEVR → `i2c_write`=0 and `req_ready`=0 immediately; after release, `req_ready`=1 within 1 cycle and a new write completes normally.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Turns one register-access request (device address, register address,
// write data) into the byte-level command stream of a single-master i2c
// block: start, address/data writes, optional restart + read, stop.
// Slave NACKs end the transfer with a stop and an error response.
//
// Optional feature macro: I2C_SEQ_RETRY_EN
//   defined   -> a NACK-terminated transfer is replayed from START up to
//                RETRIES extra times before an error is reported.
//   undefined -> the first NACK is reported directly; RETRIES is unused.
//
// Handshake rules:
//   request : a request is accepted on the rising edge where both req_valid
//             and req_ready are 1. req_ready is registered, high only in
//             IDLE, and drops the cycle after acceptance.
//   response: rsp_valid is a one-cycle pulse; rsp_rdata/rsp_err/
//             rsp_err_stage are meaningful in that cycle and hold until the
//             next response.
//   master  : i2c_write is a one-cycle strobe, raised only while i2c_ready=1,
//             with i2c_cmd/i2c_data stable in that cycle. The cycle after a
//             strobe is a gap in which i2c_ready and i2c_done_tick are
//             ignored.
// dbg_state exposes the sequencer state encoding for checkers.

module i2c_reg_sequencer #(
  parameter int RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] rsp_err_stage,
  output logic [2:0] i2c_cmd,
  output logic [7:0] i2c_data,
  output logic       i2c_write,
  input  logic       i2c_ready,
  input  logic       i2c_done_tick,
  input  logic       i2c_ack,
  input  logic [7:0] i2c_rdata,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_DEVW    = 4'd2,
    S_REG     = 4'd3,
    S_WDATA   = 4'd4,
    S_RESTART = 4'd5,
    S_DEVR    = 4'd6,
    S_READ    = 4'd7,
    S_STOP    = 4'd8,
    S_RESP    = 4'd9
  } state_t;

  // Every command state walks ISSUE -> GAP -> WAIT.
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_GAP   = 2'd1,
    PH_WAIT  = 2'd2
  } phase_t;

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_RESTART = 3'b001;
  localparam logic [2:0] CMD_STOP    = 3'b010;
  localparam logic [2:0] CMD_READ    = 3'b011;
  localparam logic [2:0] CMD_WRITE   = 3'b100;

  // NACK stage codes reported in rsp_err_stage.
  localparam logic [1:0] STG_DEVW  = 2'd0;
  localparam logic [1:0] STG_REG   = 2'd1;
  localparam logic [1:0] STG_WDATA = 2'd2;
  localparam logic [1:0] STG_DEVR  = 2'd3;

  state_t     state, state_n;
  phase_t     phase, phase_n;

  // Request fields latched at acceptance.
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;

  // Per-attempt status.
  logic       err_q;
  logic [1:0] stage_q;
  logic [7:0] rdata_q;

  logic       accept;
  logic       is_byte;
  logic       step;
  logic       nack;
  logic [1:0] nack_stage;
  logic       cap_rdata;
  logic       do_retry;
  logic       finish;

`ifdef I2C_SEQ_RETRY_EN
  localparam logic [4:0] RETRY_LIM = 5'(RETRIES);
  logic [3:0] retry_cnt;
`else
  logic [3:0] unused_retries;
  assign unused_retries = 4'(RETRIES);
`endif

  assign accept    = (state == S_IDLE) && req_valid && req_ready;
  assign dbg_state = state;

  // Next-state, phase sequencing and master command outputs.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    i2c_write  = 1'b0;
    i2c_cmd    = CMD_START;
    i2c_data   = 8'h00;
    is_byte    = 1'b0;
    step       = 1'b0;
    nack       = 1'b0;
    nack_stage = STG_DEVW;
    cap_rdata  = 1'b0;
    do_retry   = 1'b0;
    finish     = 1'b0;

    // Command and data presented by each state.
    case (state)
      S_START:   i2c_cmd = CMD_START;
      S_DEVW: begin
        i2c_cmd  = CMD_WRITE;
        i2c_data = {dev_q, 1'b0};
        is_byte  = 1'b1;
      end
      S_REG: begin
        i2c_cmd  = CMD_WRITE;
        i2c_data = reg_q;
        is_byte  = 1'b1;
      end
      S_WDATA: begin
        i2c_cmd  = CMD_WRITE;
        i2c_data = wdata_q;
        is_byte  = 1'b1;
      end
      S_RESTART: i2c_cmd = CMD_RESTART;
      S_DEVR: begin
        i2c_cmd  = CMD_WRITE;
        i2c_data = {dev_q, 1'b1};
        is_byte  = 1'b1;
      end
      S_READ: begin
        // 8'h01 tells the master this is the last byte, so it NACKs it.
        i2c_cmd  = CMD_READ;
        i2c_data = 8'h01;
        is_byte  = 1'b1;
      end
      S_STOP:    i2c_cmd = CMD_STOP;
      default: begin
        i2c_cmd  = CMD_START;
        i2c_data = 8'h00;
      end
    endcase

    if (state == S_IDLE) begin
      if (accept) begin
        state_n = S_START;
        phase_n = PH_ISSUE;
      end
    end else if (state == S_RESP) begin
      state_n = S_IDLE;
      phase_n = PH_ISSUE;
    end else begin
      case (phase)
        PH_ISSUE: begin
          if (i2c_ready) begin
            i2c_write = 1'b1;
            phase_n   = PH_GAP;
          end
        end
        PH_GAP:  phase_n = PH_WAIT;
        default: step = is_byte ? i2c_done_tick : i2c_ready;
      endcase
    end

    // Command completed: choose the following command.
    if (step) begin
      phase_n = PH_ISSUE;
      case (state)
        S_START: state_n = S_DEVW;
        S_DEVW: begin
          if (i2c_ack) begin
            nack       = 1'b1;
            nack_stage = STG_DEVW;
            state_n    = S_STOP;
          end else begin
            state_n = S_REG;
          end
        end
        S_REG: begin
          if (i2c_ack) begin
            nack       = 1'b1;
            nack_stage = STG_REG;
            state_n    = S_STOP;
          end else begin
            state_n = rw_q ? S_RESTART : S_WDATA;
          end
        end
        S_WDATA: begin
          nack       = i2c_ack;
          nack_stage = STG_WDATA;
          state_n    = S_STOP;
        end
        S_RESTART: state_n = S_DEVR;
        S_DEVR: begin
          if (i2c_ack) begin
            nack       = 1'b1;
            nack_stage = STG_DEVR;
            state_n    = S_STOP;
          end else begin
            state_n = S_READ;
          end
        end
        S_READ: begin
          cap_rdata = 1'b1;
          state_n   = S_STOP;
        end
        S_STOP: begin
`ifdef I2C_SEQ_RETRY_EN
          do_retry = err_q && ({1'b0, retry_cnt} < RETRY_LIM);
`endif
          if (do_retry) begin
            state_n = S_START;
          end else begin
            finish  = 1'b1;
            state_n = S_RESP;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      phase <= PH_ISSUE;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // Registered ready: high exactly while the sequencer will sit in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (state_n == S_IDLE);
    end
  end

  // Latch request fields so later input changes do not disturb the transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else if (accept) begin
      rw_q    <= req_rw;
      dev_q   <= req_dev_addr;
      reg_q   <= req_reg_addr;
      wdata_q <= req_wdata;
    end
  end

  // Attempt status: NACK flag/stage and captured read byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      stage_q <= 2'd0;
      rdata_q <= 8'h00;
    end else if (accept || do_retry) begin
      err_q   <= 1'b0;
      stage_q <= 2'd0;
      rdata_q <= 8'h00;
    end else begin
      if (nack) begin
        err_q   <= 1'b1;
        stage_q <= nack_stage;
      end
      if (cap_rdata) begin
        rdata_q <= i2c_rdata;
      end
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  // Count replays of the current request; cleared when a new one arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= 4'd0;
    end else if (accept) begin
      retry_cnt <= 4'd0;
    end else if (do_retry) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end
`endif

  // Response pulse and fields, loaded once the final stop has completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'h00;
      rsp_err       <= 1'b0;
      rsp_err_stage <= 2'd0;
    end else begin
      rsp_valid <= finish;
      if (finish) begin
        rsp_rdata     <= err_q ? 8'h00 : rdata_q;
        rsp_err       <= err_q;
        rsp_err_stage <= stage_q;
      end
    end
  end

endmodule
